// File: rtl/sw_result_collector.sv
// Per-query summary collector for the SmithWaterman score stream: tracks indices,
// best score/match and hit count, and queues one summary per query in a small FIFO.
module sw_result_collector #(
  parameter int CALC_BIT   = 16,
  parameter int T_IDX_BIT  = 10,
  parameter int Q_IDX_BIT  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 valid_i,
  input  logic [CALC_BIT-1:0]  result_i,
  input  logic                 change_q_i,
  input  logic [CALC_BIT-1:0]  threshold_i,
  input  logic                 tie_last_i,
  output logic [T_IDX_BIT-1:0] t_idx_o,
  output logic [Q_IDX_BIT-1:0] q_idx_o,
  output logic                 sum_valid_o,
  input  logic                 sum_ready_i,
  output logic [Q_IDX_BIT-1:0] sum_q_idx_o,
  output logic [T_IDX_BIT-1:0] sum_match_idx_o,
  output logic [CALC_BIT-1:0]  sum_max_o,
  output logic [T_IDX_BIT-1:0] sum_hits_o,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int PTR_BIT = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BIT = PTR_BIT + 1;
  localparam logic [T_IDX_BIT-1:0] T_ONE  = T_IDX_BIT'(1'b1);
  localparam logic [Q_IDX_BIT-1:0] Q_ONE  = Q_IDX_BIT'(1'b1);
  localparam logic [PTR_BIT-1:0]   P_ONE  = PTR_BIT'(1'b1);
  localparam logic [CNT_BIT-1:0]   C_ONE  = CNT_BIT'(1'b1);
  localparam logic [CNT_BIT-1:0]   C_FULL = CNT_BIT'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [Q_IDX_BIT-1:0] q_idx;
    logic [T_IDX_BIT-1:0] match_idx;
    logic [CALC_BIT-1:0]  max_score;
    logic [T_IDX_BIT-1:0] hits;
  } summary_t;

  state_t               state_r, state_nxt_s;
  logic                 run_s;
  logic [T_IDX_BIT-1:0] t_idx_r, t_idx_nxt_s;
  logic [Q_IDX_BIT-1:0] q_idx_r, q_idx_nxt_s;
  logic [CALC_BIT-1:0]  max_r, max_nxt_s, cur_max_s;
  logic [T_IDX_BIT-1:0] match_r, match_nxt_s, cur_match_s;
  logic [T_IDX_BIT-1:0] hits_r, hits_nxt_s, cur_hits_s;
  logic                 accept_s, push_s, pop_s, full_s, do_push_s, drop_s;
  summary_t             push_entry_s, head_s;
  summary_t             fifo_mem_r [FIFO_DEPTH];
  logic [PTR_BIT-1:0]   wr_ptr_r, wr_ptr_nxt_s, rd_ptr_r, rd_ptr_nxt_s;
  logic [CNT_BIT-1:0]   count_r, count_nxt_s;
  logic                 overflow_r, overflow_nxt_s;
  logic                 sum_valid_r, busy_r;

  // Session state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Session next state: start_i enters RUN from anywhere; RUN is only left by reset
  always_comb begin
    state_nxt_s = state_r;
    run_s       = 1'b0;
    case (state_r)
      IDLE: begin
        run_s = 1'b0;
        if (start_i) state_nxt_s = RUN;
        else         state_nxt_s = IDLE;
      end
      RUN: begin
        run_s       = 1'b1;
        state_nxt_s = RUN;
      end
      default: begin
        run_s       = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // A start in the same cycle discards the incoming result
  assign accept_s = run_s & valid_i & ~start_i;
  assign push_s   = accept_s & change_q_i;

  // Running best/match/hits including the current result
  always_comb begin
    cur_max_s   = max_r;
    cur_match_s = match_r;
    cur_hits_s  = hits_r;
    if (t_idx_r == '0) begin
      cur_max_s   = result_i;
      cur_match_s = '0;
    end else if ((result_i > max_r) || ((result_i == max_r) && tie_last_i)) begin
      cur_max_s   = result_i;
      cur_match_s = t_idx_r;
    end else begin
      cur_max_s   = max_r;
      cur_match_s = match_r;
    end
    if ((result_i >= threshold_i) && (hits_r != '1)) cur_hits_s = hits_r + T_ONE;
    else                                             cur_hits_s = hits_r;
  end

  // Index and running-statistics next values
  always_comb begin
    t_idx_nxt_s = t_idx_r;
    q_idx_nxt_s = q_idx_r;
    max_nxt_s   = max_r;
    match_nxt_s = match_r;
    hits_nxt_s  = hits_r;
    if (start_i) begin
      t_idx_nxt_s = '0;
      q_idx_nxt_s = '0;
      max_nxt_s   = '0;
      match_nxt_s = '0;
      hits_nxt_s  = '0;
    end else if (accept_s && change_q_i) begin
      t_idx_nxt_s = '0;
      q_idx_nxt_s = q_idx_r + Q_ONE;
      max_nxt_s   = '0;
      match_nxt_s = '0;
      hits_nxt_s  = '0;
    end else if (accept_s) begin
      t_idx_nxt_s = t_idx_r + T_ONE;
      max_nxt_s   = cur_max_s;
      match_nxt_s = cur_match_s;
      hits_nxt_s  = cur_hits_s;
    end else begin
      t_idx_nxt_s = t_idx_r;
      q_idx_nxt_s = q_idx_r;
    end
  end

  // Index and running-statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_idx_r <= '0;
      q_idx_r <= '0;
      max_r   <= '0;
      match_r <= '0;
      hits_r  <= '0;
    end else begin
      t_idx_r <= t_idx_nxt_s;
      q_idx_r <= q_idx_nxt_s;
      max_r   <= max_nxt_s;
      match_r <= match_nxt_s;
      hits_r  <= hits_nxt_s;
    end
  end

  assign push_entry_s = '{q_idx: q_idx_r, match_idx: cur_match_s,
                          max_score: cur_max_s, hits: cur_hits_s};

  // When full, a simultaneous pop frees the slot the new entry is written into
  assign pop_s     = sum_valid_r & sum_ready_i;
  assign full_s    = (count_r == C_FULL);
  assign do_push_s = push_s & (~full_s | pop_s);
  assign drop_s    = push_s & full_s & ~pop_s;

  // FIFO pointer, occupancy and overflow next values
  always_comb begin
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    if (start_i) begin
      wr_ptr_nxt_s   = '0;
      rd_ptr_nxt_s   = '0;
      count_nxt_s    = '0;
      overflow_nxt_s = 1'b0;
    end else begin
      if (do_push_s) wr_ptr_nxt_s = wr_ptr_r + P_ONE;
      else           wr_ptr_nxt_s = wr_ptr_r;
      if (pop_s) rd_ptr_nxt_s = rd_ptr_r + P_ONE;
      else       rd_ptr_nxt_s = rd_ptr_r;
      case ({do_push_s, pop_s})
        2'b10:   count_nxt_s = count_r + C_ONE;
        2'b01:   count_nxt_s = count_r - C_ONE;
        default: count_nxt_s = count_r;
      endcase
      overflow_nxt_s = overflow_r | drop_s;
    end
  end

  // FIFO control and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      sum_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_nxt_s;
      sum_valid_r <= (count_nxt_s != '0);
      busy_r      <= (state_nxt_s == RUN) || (count_nxt_s != '0);
    end
  end

  // Summary storage; cleared on reset so the sum_* outputs start at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= '0;
    end else if (do_push_s) begin
      fifo_mem_r[wr_ptr_r] <= push_entry_s;
    end
  end

  assign head_s          = fifo_mem_r[rd_ptr_r];
  assign t_idx_o         = t_idx_r;
  assign q_idx_o         = q_idx_r;
  assign sum_valid_o     = sum_valid_r;
  assign sum_q_idx_o     = head_s.q_idx;
  assign sum_match_idx_o = head_s.match_idx;
  assign sum_max_o       = head_s.max_score;
  assign sum_hits_o      = head_s.hits;
  assign overflow_o      = overflow_r;
  assign busy_o          = busy_r;

endmodule

// File: tb/tb_sw_result_collector.sv
// Bench for sw_result_collector: directed scenarios plus randomized traffic, checked
// against a queue-based model that recomputes each summary from the query's raw scores.
module tb_sw_result_collector;

  localparam int CB = 16;
  localparam int TB = 3;
  localparam int QB = 8;
  localparam int D  = 4;
  localparam int TMOD = 1 << TB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0, valid_i = 1'b0, change_q_i = 1'b0;
  logic          tie_last_i = 1'b0, sum_ready_i = 1'b0;
  logic [CB-1:0] result_i = '0, threshold_i = '0;
  logic [TB-1:0] t_idx_o, sum_match_idx_o, sum_hits_o;
  logic [QB-1:0] q_idx_o, sum_q_idx_o;
  logic [CB-1:0] sum_max_o;
  logic          sum_valid_o, overflow_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int q;
    int match;
    int mx;
    int hits;
  } sum_t;

  bit   m_run = 1'b0;
  bit   m_ovf = 1'b0;
  int   m_t = 0;
  int   m_q = 0;
  int   qres[$];
  sum_t mfifo[$];

  sw_result_collector #(.CALC_BIT(CB), .T_IDX_BIT(TB), .Q_IDX_BIT(QB), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .valid_i(valid_i), .result_i(result_i),
    .change_q_i(change_q_i), .threshold_i(threshold_i), .tie_last_i(tie_last_i),
    .t_idx_o(t_idx_o), .q_idx_o(q_idx_o), .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i),
    .sum_q_idx_o(sum_q_idx_o), .sum_match_idx_o(sum_match_idx_o), .sum_max_o(sum_max_o),
    .sum_hits_o(sum_hits_o), .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Best score is taken over the scores since the index last wrapped to 0;
  // hits count the whole query and saturate at the index width.
  function automatic sum_t summarize();
    sum_t s;
    int n = qres.size();
    int p = ((n - 1) / TMOD) * TMOD;
    s.q = m_q;
    s.hits = 0;
    foreach (qres[k]) if (qres[k] >= int'(threshold_i)) s.hits++;
    if (s.hits > TMOD - 1) s.hits = TMOD - 1;
    s.mx = qres[p];
    for (int k = p; k < n; k++) if (qres[k] > s.mx) s.mx = qres[k];
    s.match = -1;
    for (int k = p; k < n; k++) begin
      if (qres[k] == s.mx && (tie_last_i || s.match < 0)) s.match = k - p;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_ovf = 1'b0; m_t = 0; m_q = 0;
    qres.delete();
    mfifo.delete();
  endtask

  task automatic model_edge(input bit s, input bit v, input bit cq, input int r, input bit rdy);
    bit   pop = (mfifo.size() > 0) && rdy;
    sum_t sm;
    if (s) begin
      model_reset();
      m_run = 1'b1;
    end else begin
      if (pop) void'(mfifo.pop_front());
      if (m_run && v) begin
        qres.push_back(r);
        if (cq) begin
          sm = summarize();
          if (mfifo.size() < D) mfifo.push_back(sm);
          else m_ovf = 1'b1;
          qres.delete();
          m_t = 0;
          m_q = (m_q + 1) % (1 << QB);
        end else begin
          m_t = (m_t + 1) % TMOD;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("t_idx", t_idx_o, m_t);
    chk("q_idx", q_idx_o, m_q);
    chk("sum_valid", sum_valid_o, mfifo.size() > 0);
    chk("overflow", overflow_o, m_ovf);
    chk("busy", busy_o, m_run || (mfifo.size() > 0));
    if (mfifo.size() > 0) begin
      chk("head_q", sum_q_idx_o, mfifo[0].q);
      chk("head_match", sum_match_idx_o, mfifo[0].match);
      chk("head_max", sum_max_o, mfifo[0].mx);
      chk("head_hits", sum_hits_o, mfifo[0].hits);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_t_idx"}, t_idx_o, 0);
    chk({tag, "_q_idx"}, q_idx_o, 0);
    chk({tag, "_sum_valid"}, sum_valid_o, 0);
    chk({tag, "_sum_q"}, sum_q_idx_o, 0);
    chk({tag, "_sum_match"}, sum_match_idx_o, 0);
    chk({tag, "_sum_max"}, sum_max_o, 0);
    chk({tag, "_sum_hits"}, sum_hits_o, 0);
    chk({tag, "_overflow"}, overflow_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic step(input bit s, input bit v, input bit cq, input int r, input bit rdy);
    start_i = s; valid_i = v; change_q_i = cq; result_i = r[CB-1:0]; sum_ready_i = rdy;
    @(posedge clk);
    model_edge(s, v, cq, r, rdy);
    #1;
    check_all();
  endtask

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Basic: 5,9,3 with threshold 4
    threshold_i = 16'd4; tie_last_i = 1'b0;
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 5, 1'b1);
    step(1'b0, 1'b1, 1'b0, 9, 1'b1);
    step(1'b0, 1'b1, 1'b1, 3, 1'b1);
    chk("basic_valid", sum_valid_o, 1);
    chk("basic_match", sum_match_idx_o, 1);
    chk("basic_max", sum_max_o, 9);
    chk("basic_hits", sum_hits_o, 2);
    chk("basic_qidx", q_idx_o, 1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Ties: earliest then latest wins
    for (int tl = 0; tl < 2; tl++) begin
      tie_last_i = tl[0];
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 7, 1'b0);
      step(1'b0, 1'b1, 1'b0, 7, 1'b0);
      step(1'b0, 1'b1, 1'b1, 7, 1'b0);
      chk("tie_match", sum_match_idx_o, tl * 2);
    end

    // Back-pressure and overflow, then drain
    tie_last_i = 1'b0;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 1'b1, k, 1'b0);
    chk("ovf_set", overflow_o, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("ovf_sticky", overflow_o, 1);

    // Full FIFO: push and pop in the same cycle
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b1, 10 + k, 1'b0);
    step(1'b0, 1'b1, 1'b1, 15, 1'b1);
    chk("pushpop_ovf", overflow_o, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Index wrap and hit saturation
    threshold_i = 16'd1;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 2 + k, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3, 1'b0);
    chk("wrap_hits", sum_hits_o, 7);

    // Asynchronous reset mid-query
    step(1'b0, 1'b1, 1'b0, 4, 1'b0);
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // valid in IDLE is ignored, start beats valid
    step(1'b0, 1'b1, 1'b1, 5, 1'b1);
    step(1'b1, 1'b1, 1'b0, 9, 1'b1);
    step(1'b0, 1'b1, 1'b1, 3, 1'b0);
    chk("start_disc_max", sum_max_o, 3);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Randomized traffic, one block per tie policy
    threshold_i = 16'd8;
    for (int tl = 0; tl < 2; tl++) begin
      tie_last_i = tl[0];
      step(1'b1, 1'b0, 1'b0, 0, 1'b1);
      for (int c = 0; c < 1500; c++) begin
        step(1'b0, ($urandom % 4) != 0, ($urandom % 6) == 0,
             int'($urandom_range(0, 15)), ($urandom % 3) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sw_result_collector.md
# sw_result_collector

Synthesizable, parametrised collector for the SmithWaterman score stream. It consumes per-target results (`result`, `valid`, `change_q`), tracks target/query indices, running best score, best-match index and above-threshold hit count, and pushes one per-query summary into an N-deep FIFO with a valid/ready handshake. It sits between `SmithWaterman` and the host/readout logic, replacing the bench-side bookkeeping with hardware that tolerates output back-pressure.

## Interface

Parameters:
- `CALC_BIT`, 16: score width; matches `` `CALC_BIT``.
- `T_IDX_BIT`, 10: target-index width; matches `` `MAX_T_NUM_BIT``.
- `Q_IDX_BIT`, 8: query-index width.
- `FIFO_DEPTH`, 4: summary FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start_i`  in  1  synchronous session clear.
- `valid_i`  in  1  result strobe.
- `result_i`  in  CALC_BIT  score, unsigned.
- `change_q_i`  in  1  qualifies `valid_i`: last target of current query.
- `threshold_i`  in  CALC_BIT  hit threshold, static during a session.
- `tie_last_i`  in  1  0: earliest target wins ties; 1: latest wins.
- `t_idx_o`  out  T_IDX_BIT  index of next expected target.
- `q_idx_o`  out  Q_IDX_BIT  index of current query.
- `sum_valid_o`  out  1  FIFO head valid.
- `sum_ready_i`  in  1  consumer accepts head.
- `sum_q_idx_o`  out  Q_IDX_BIT  query index of head.
- `sum_match_idx_o`  out  T_IDX_BIT  best target of head.
- `sum_max_o`  out  CALC_BIT  best score of head.
- `sum_hits_o`  out  T_IDX_BIT  targets with score ≥ threshold.
- `overflow_o`  out  1  sticky: a summary was dropped.
- `busy_o`  out  1  session active or FIFO non-empty.

## Operation

- States: `IDLE`, `RUN`. Reset → `IDLE`. `start_i` from any state → `RUN`, clearing `t_idx`, `q_idx`, running max, match index, hit count, FIFO pointers and `overflow_o`.
- In `RUN`, each cycle with `valid_i`=1:
  - First target of a query (`t_idx`=0): running max ← `result_i`, match ← 0.
  - Otherwise: replace if `result_i` > max, or if equal and `tie_last_i`=1; match ← `t_idx`.
  - Hits += 1 if `result_i` ≥ `threshold_i`; saturate at all-ones.
  - `change_q_i`=0: `t_idx` += 1, wrapping mod 2^T_IDX_BIT.
  - `change_q_i`=1: push summary `{q_idx, match, max, hits}`, computed including the current result. Then `t_idx` ← 0, `q_idx` += 1 (wraps), running max/match/hits cleared.
- `valid_i` in `IDLE` is ignored: no counters move and nothing is pushed.
- `valid_i` and `start_i` in the same cycle: `start_i` wins and the result is discarded.
- FIFO push while full with no pop in that cycle: summary dropped, `overflow_o` ← 1 (sticky until `start_i`/reset). Push and pop in the same cycle when full: both happen.
- Pop occurs when `sum_valid_o & sum_ready_i`. The head and `sum_*` fields hold stable while `sum_valid_o`=1 and `sum_ready_i`=0.
- `busy_o` = (state==`RUN`) | FIFO non-empty. A session never returns to `IDLE` on its own; it leaves only on reset. `start_i` re-enters `RUN`.

## Timing

- Reset values: all outputs 0; state `IDLE`; FIFO empty.
- `t_idx_o`/`q_idx_o` are registers and update the cycle after the strobe.
- Summary latency: `valid_i & change_q_i` sampled at edge N → `sum_valid_o`=1 from edge N (visible in cycle N+1) when FIFO was empty.
- Throughput: one result per cycle sustained; one summary pop per cycle.
- `sum_*` are driven from FIFO storage/registers, with no combinational path from `valid_i`/`result_i`.
- Asynchronous reset mid-operation: immediate clear; in-flight summaries lost; `overflow_o` cleared.

## Test plan

- Basic: `start_i`; results 5,9,3 with `change_q_i` on the 3rd; threshold 4; `sum_ready_i`=1 → one summary q=0, match=1, max=9, hits=2; `t_idx_o`=0, `q_idx_o`=1.
- Ties: results 7,7,7, last with `change_q_i`; `tie_last_i`=0 → match 0. Repeat with `tie_last_i`=1 → match 2.
- Back-pressure/overflow: DEPTH=4, `sum_ready_i`=0, 5 single-target queries with scores 1..5 → 4 entries held stable, `overflow_o`=1. Then raise ready → pops q=0..3 with max 1..4 on consecutive cycles.
- Full push+pop: FIFO full, `sum_ready_i`=1 in the same cycle as a 5th `change_q_i` → no overflow; FIFO stays full; the new entry is at the tail.
- Wrap/saturate: T_IDX_BIT=3, 10 results all ≥ threshold before `change_q_i` → `t_idx` wraps through 7→0 and hits saturate at 7.
- Reset/start: `rst_n`=0 mid-query → all outputs 0 asynchronously. `start_i` together with `valid_i` → result discarded and counters 0. `valid_i` in `IDLE` → no change.
